// File: rtl/pseinv_row_sequencer.sv
`timescale 1ns/1ps
// pseinv_row_sequencer
//   Walks the pseudoinverse build one row at a time. For each row it asks
//   the row-compute unit for the row, waits for the result under a watchdog,
//   then pulses the builder write enable with the row position.
//
// Ports
//   clk, rst            rising-edge clock, async active-high reset
//   start, abort        solve control (start only honoured when idle)
//   row_req/row_ack     request handshake to the row-compute unit
//   row_valid           one-cycle "row result ready" pulse
//   row_idx             row currently requested / being computed
//   build_en/build_pos  one-cycle builder write strobe and row position
//   busy, done, err     status: build running, build complete pulse,
//                       sticky watchdog timeout
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | no build running; waits for start
// S_REQ    | row_req held for row k until row_ack
// S_WAIT   | waiting for row_valid of row k, watchdog counting
// S_WRITE  | build_en/build_pos=k on the outputs this cycle
// S_FINISH | done pulse; returns to idle

module pseinv_row_sequencer #(
  parameter int nBits   = 32,
  parameter int N       = 4,
  parameter int M       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             row_req,
  input  logic             row_ack,
  input  logic             row_valid,
  output logic [nBits-1:0] row_idx,
  output logic             build_en,
  output logic [nBits-1:0] build_pos,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Row counter is kept narrow; one bit minimum so N=1 still elaborates.
  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [KW-1:0]  K_LAST  = KW'(N - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_MAX  = {WDW{1'b1}};

  if (N < 1 || M < 1 || TIMEOUT < 2) begin : g_bad_param
    $error("pseinv_row_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [KW-1:0]    k_inc;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic             row_req_q, row_req_d;
  logic             build_en_q, build_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [nBits-1:0] row_idx_q, row_idx_d;
  logic [nBits-1:0] build_pos_q, build_pos_d;

  assign k_inc = k_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      wdog_q      <= '0;
      row_req_q   <= 1'b0;
      build_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      row_idx_q   <= '0;
      build_pos_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wdog_q      <= wdog_d;
      row_req_q   <= row_req_d;
      build_en_q  <= build_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      row_idx_q   <= row_idx_d;
      build_pos_q <= build_pos_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wdog_d      = wdog_q;
    row_req_d   = row_req_q;
    build_en_d  = 1'b0;
    build_pos_d = build_pos_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    row_idx_d   = row_idx_q;

    // abort outranks every handshake and the watchdog; err is left alone
    if (state_q != S_IDLE && abort) begin
      state_d   = S_IDLE;
      k_d       = '0;
      wdog_d    = '0;
      row_req_d = 1'b0;
      busy_d    = 1'b0;
      row_idx_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_REQ;
            k_d       = '0;
            row_idx_d = '0;
            row_req_d = 1'b1;
            busy_d    = 1'b1;
            err_d     = 1'b0;
          end
        end
        S_REQ: begin
          if (row_ack) begin
            state_d   = S_WAIT;
            row_req_d = 1'b0;
            wdog_d    = '0;
          end
        end
        S_WAIT: begin
          // a result arriving on the timeout cycle is still taken
          if (row_valid) begin
            state_d     = S_WRITE;
            build_en_d  = 1'b1;
            build_pos_d = nBits'(k_q);
          end else if (wdog_q == WD_LAST) begin
            state_d   = S_IDLE;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            k_d       = '0;
            row_idx_d = '0;
          end else if (wdog_q != WD_MAX) begin
            wdog_d = wdog_q + 1'b1;
          end
        end
        S_WRITE: begin
          if (k_q == K_LAST) begin
            state_d   = S_FINISH;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            row_idx_d = '0;
          end else begin
            state_d   = S_REQ;
            k_d       = k_inc;
            row_idx_d = nBits'(k_inc);
            row_req_d = 1'b1;
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign row_req   = row_req_q;
  assign row_idx   = row_idx_q;
  assign build_en  = build_en_q;
  assign build_pos = build_pos_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
